// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory-access stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } lsu_state_e;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseTimeout  = 2'b10;
    localparam logic [1:0] CauseIllegal  = 2'b11;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        case (f3)
            Funct3B, Funct3H, Funct3W: return 1'b0;
            Funct3Bu, Funct3Hu:        return is_store;
            default:                   return 1'b1;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replication, load right-shift to bit 0.
module lsu_lane_align (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            2'b00: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign o_ldata = i_rdata >> {i_ld_off, 3'b000};

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store memory-access stage: alignment/legality check, bus handshake with
// watchdog, and lane-shifted load data handed to the load extender.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemValid,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic [2:0]  LoadFunct3,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemBe,
    output logic [31:0] DMemWData,
    input  logic        DMemGnt,
    input  logic        DMemRValid,
    input  logic [31:0] DMemRData
);

    lsu_state_e  r_state, w_state_d;
    logic        r_we, w_we_d;
    logic [2:0]  r_funct3, w_funct3_d;
    logic [1:0]  r_off, w_off_d;
    logic [31:0] r_cnt, w_cnt_d;
    logic        r_done, w_done_d;
    logic        r_fault, w_fault_d;
    logic [1:0]  r_cause, w_cause_d;
    logic [31:0] r_ldata, w_ldata_d;
    logic [2:0]  r_lfunct3, w_lfunct3_d;
    logic        r_req, w_req_d;
    logic        r_dwe, w_dwe_d;
    logic [31:0] r_daddr, w_daddr_d;
    logic [3:0]  r_be, w_be_d;
    logic [31:0] r_wdata, w_wdata_d;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    logic [31:0] w_cnt_inc;
    logic        w_timeout;

    lsu_lane_align u_lane_align (
        .i_size   (funct3[1:0]),
        .i_st_off (Addr[1:0]),
        .i_wdata  (WriteData),
        .i_ld_off (r_off),
        .i_rdata  (DMemRData),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_ldata  (w_ldata)
    );

    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        w_state_d   = r_state;
        w_we_d      = r_we;
        w_funct3_d  = r_funct3;
        w_off_d     = r_off;
        w_cnt_d     = r_cnt;
        w_done_d    = 1'b0;
        w_fault_d   = r_fault;
        w_cause_d   = r_cause;
        w_ldata_d   = r_ldata;
        w_lfunct3_d = r_lfunct3;
        w_req_d     = r_req;
        w_dwe_d     = r_dwe;
        w_daddr_d   = r_daddr;
        w_be_d      = r_be;
        w_wdata_d   = r_wdata;

        unique case (r_state)
            StIdle: begin
                if (MemValid) begin
                    w_we_d     = MemWrite;
                    w_funct3_d = funct3;
                    w_off_d    = Addr[1:0];
                    if (f3_illegal(funct3, MemWrite) || f3_misaligned(funct3, Addr[1:0])) begin
                        w_state_d   = StDone;
                        w_done_d    = 1'b1;
                        w_fault_d   = 1'b1;
                        w_cause_d   = f3_illegal(funct3, MemWrite) ? CauseIllegal : CauseMisalign;
                        w_ldata_d   = 32'h0;
                        w_lfunct3_d = funct3;
                    end else begin
                        w_state_d = StReq;
                        w_cnt_d   = 32'h0;
                        w_req_d   = 1'b1;
                        w_dwe_d   = MemWrite;
                        w_daddr_d = {Addr[31:2], 2'b00};
                        // Loads fetch the whole word; lanes are picked on return.
                        w_be_d    = MemWrite ? w_be : 4'b0000;
                        w_wdata_d = MemWrite ? w_wdata : 32'h0;
                    end
                end
            end
            StReq: begin
                if (DMemGnt) begin
                    w_req_d = 1'b0;
                    w_cnt_d = w_cnt_inc;
                    if (r_we) begin
                        w_state_d   = StDone;
                        w_done_d    = 1'b1;
                        w_fault_d   = 1'b0;
                        w_cause_d   = CauseNone;
                        w_ldata_d   = 32'h0;
                        w_lfunct3_d = r_funct3;
                    end else begin
                        w_state_d = StResp;
                    end
                end else if (w_timeout) begin
                    w_req_d     = 1'b0;
                    w_state_d   = StDone;
                    w_done_d    = 1'b1;
                    w_fault_d   = 1'b1;
                    w_cause_d   = CauseTimeout;
                    w_ldata_d   = 32'h0;
                    w_lfunct3_d = r_funct3;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            StResp: begin
                if (DMemRValid) begin
                    w_state_d   = StDone;
                    w_done_d    = 1'b1;
                    w_fault_d   = 1'b0;
                    w_cause_d   = CauseNone;
                    w_ldata_d   = w_ldata;
                    w_lfunct3_d = r_funct3;
                end else if (w_timeout) begin
                    w_state_d   = StDone;
                    w_done_d    = 1'b1;
                    w_fault_d   = 1'b1;
                    w_cause_d   = CauseTimeout;
                    w_ldata_d   = 32'h0;
                    w_lfunct3_d = r_funct3;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_off     <= 2'b00;
            r_cnt     <= 32'h0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_cause   <= CauseNone;
            r_ldata   <= 32'h0;
            r_lfunct3 <= 3'b000;
            r_req     <= 1'b0;
            r_dwe     <= 1'b0;
            r_daddr   <= 32'h0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0;
        end else begin
            r_state   <= w_state_d;
            r_we      <= w_we_d;
            r_funct3  <= w_funct3_d;
            r_off     <= w_off_d;
            r_cnt     <= w_cnt_d;
            r_done    <= w_done_d;
            r_fault   <= w_fault_d;
            r_cause   <= w_cause_d;
            r_ldata   <= w_ldata_d;
            r_lfunct3 <= w_lfunct3_d;
            r_req     <= w_req_d;
            r_dwe     <= w_dwe_d;
            r_daddr   <= w_daddr_d;
            r_be      <= w_be_d;
            r_wdata   <= w_wdata_d;
        end
    end

    assign Stall      = MemValid && !r_done;
    assign Done       = r_done;
    assign LoadData   = r_ldata;
    assign LoadFunct3 = r_lfunct3;
    assign Fault      = r_fault;
    assign FaultCause = r_cause;
    assign DMemReq    = r_req;
    assign DMemWe     = r_dwe;
    assign DMemAddr   = r_daddr;
    assign DMemBe     = r_be;
    assign DMemWData  = r_wdata;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: stimulus pushes expected bus and completion
// records, a bus responder and a completion monitor pop and compare them.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        MemValid = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Stall, Done, Fault;
    logic [31:0] LoadData;
    logic [2:0]  LoadFunct3;
    logic [1:0]  FaultCause;
    logic        DMemReq, DMemWe;
    logic [31:0] DMemAddr, DMemWData;
    logic [3:0]  DMemBe;
    logic        DMemGnt = 1'b0;
    logic        DMemRValid = 1'b0;
    logic [31:0] DMemRData = 32'h0;

    lsu_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemValid   (MemValid),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .Stall      (Stall),
        .Done       (Done),
        .LoadData   (LoadData),
        .LoadFunct3 (LoadFunct3),
        .Fault      (Fault),
        .FaultCause (FaultCause),
        .DMemReq    (DMemReq),
        .DMemWe     (DMemWe),
        .DMemAddr   (DMemAddr),
        .DMemBe     (DMemBe),
        .DMemWData  (DMemWData),
        .DMemGnt    (DMemGnt),
        .DMemRValid (DMemRValid),
        .DMemRData  (DMemRData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        fault;
        logic [1:0]  cause;
        logic        chk_ld;
        logic [31:0] ldata;
        logic [2:0]  lf3;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    logic [31:0] mem [logic [31:0]];

    int   gnt_wait = 0;
    bit   no_grant = 1'b0;
    bit   no_rvalid = 1'b0;
    int   wc = 0;
    bit   rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'h0;
    bit   prev_req = 1'b0;
    int   req_cycles = 0;
    resp_t mon_e;
    bus_t  rsp_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Bus responder: checks request fields while held, grants after gnt_wait cycles.
    initial begin
        forever begin
            @(negedge clk);
            DMemGnt    = 1'b0;
            DMemRValid = 1'b0;
            DMemRData  = 32'h0;
            if (!reset_n) begin
                wc = 0; rd_pend = 1'b0; prev_req = 1'b0; req_cycles = 0;
                continue;
            end
            if (rd_pend) begin
                DMemRValid = 1'b1;
                DMemRData  = mem_rd(rd_addr);
                rd_pend    = 1'b0;
            end
            if (DMemReq) begin
                req_cycles++;
                if (bus_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    rsp_b = bus_q[0];
                    check("bus_we", {31'h0, DMemWe}, {31'h0, rsp_b.we});
                    check("bus_addr", DMemAddr, rsp_b.addr);
                    check("bus_be", {28'h0, DMemBe}, {28'h0, rsp_b.be});
                    if (rsp_b.we) check("bus_wdata", DMemWData, rsp_b.wd);
                    if (!no_grant) begin
                        if (wc < gnt_wait) begin
                            wc++;
                        end else begin
                            DMemGnt = 1'b1;
                            wc = 0;
                            req_cycles = 0;
                            void'(bus_q.pop_front());
                            if (DMemWe) begin
                                logic [31:0] w;
                                w = mem_rd(DMemAddr);
                                for (int i = 0; i < 4; i++)
                                    if (DMemBe[i]) w[8*i +: 8] = DMemWData[8*i +: 8];
                                mem[DMemAddr] = w;
                            end else if (!no_rvalid) begin
                                rd_pend = 1'b1;
                                rd_addr = DMemAddr;
                            end
                        end
                    end
                end
            end else if (prev_req && no_grant) begin
                check("timeout_req_cycles", req_cycles, 32'd4);
                req_cycles = 0;
                if (bus_q.size() > 0) void'(bus_q.pop_front());
                // Late read data after the abort must be ignored.
                DMemRValid = 1'b1;
                DMemRData  = 32'hFFFF_FFFF;
            end
            prev_req = DMemReq;
        end
    end

    // Completion monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && Done) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = resp_q.pop_front();
                    check({mon_e.name, "_fault"}, {31'h0, Fault}, {31'h0, mon_e.fault});
                    check({mon_e.name, "_cause"}, {30'h0, FaultCause}, {30'h0, mon_e.cause});
                    check({mon_e.name, "_funct3"}, {29'h0, LoadFunct3}, {29'h0, mon_e.lf3});
                    if (mon_e.chk_ld) check({mon_e.name, "_ldata"}, LoadData, mon_e.ldata);
                    check({mon_e.name, "_latency"}, cyc - mon_e.t0, mon_e.lat);
                end
            end
        end
    end

    task automatic access(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int gw,
                          input bit ng, input bit has_bus, input logic [3:0] be,
                          input logic [31:0] bwd, input logic fault, input logic [1:0] cause,
                          input logic chk_ld, input logic [31:0] ldata, input int lat);
        resp_t r;
        bus_t  b;
        bit    seen;
        r.name = name; r.fault = fault; r.cause = cause; r.chk_ld = chk_ld;
        r.ldata = ldata; r.lf3 = f3; r.lat = lat; r.t0 = cyc;
        resp_q.push_back(r);
        if (has_bus) begin
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.be = be; b.wd = bwd;
            bus_q.push_back(b);
        end
        gnt_wait  = gw;
        no_grant  = ng;
        no_rvalid = 1'b0;
        MemValid  = 1'b1;
        MemWrite  = we;
        funct3    = f3;
        Addr      = addr;
        WriteData = wd;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check({name, "_stall"}, {31'h0, Stall}, {31'h0, (i + 1 < lat)});
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_done: no Done within 40 cycles, required after %0d", name, lat);
        end
        @(negedge clk);
        MemValid = 1'b0;
        no_grant = 1'b0;
    endtask

    initial begin
        mem[32'h100] = 32'hAABB_CCDD;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'h0, Done}, 32'h0);
        check("rst_fault", {31'h0, Fault}, 32'h0);
        check("rst_cause", {30'h0, FaultCause}, 32'h0);
        check("rst_ldata", LoadData, 32'h0);
        check("rst_lf3", {29'h0, LoadFunct3}, 32'h0);
        check("rst_req", {31'h0, DMemReq}, 32'h0);
        check("rst_we", {31'h0, DMemWe}, 32'h0);
        check("rst_addr", DMemAddr, 32'h0);
        check("rst_be", {28'h0, DMemBe}, 32'h0);
        check("rst_wdata", DMemWData, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        //     name    we  f3      addr          wdata         gw ng bus be       bwd           flt cause  ld  ldata         lat
        access("lbu",  0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        0, 2'b00, 1, 32'h0000_00AA, 3);
        access("sh",   1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 2, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 2'b00, 0, 32'h0,        4);
        access("lh",   0, 3'b001, 32'h0000_0202, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        0, 2'b00, 1, 32'h0000_ABCD, 3);
        access("lw_mis", 0, 3'b010, 32'h0000_0301, 32'h0,      0, 0, 0, 4'b0000, 32'h0,        1, 2'b01, 0, 32'h0,        1);
        access("f3_011", 0, 3'b011, 32'h0000_0000, 32'h0,      0, 0, 0, 4'b0000, 32'h0,        1, 2'b11, 0, 32'h0,        1);
        access("sbu",  1, 3'b100, 32'h0000_0010, 32'h55,       0, 0, 0, 4'b0000, 32'h0,        1, 2'b11, 0, 32'h0,        1);
        access("sh_mis", 1, 3'b001, 32'h0000_0201, 32'h77,     0, 0, 0, 4'b0000, 32'h0,        1, 2'b01, 0, 32'h0,        1);
        access("sw",   1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0, 2'b00, 0, 32'h0,       2);
        access("lw",   0, 3'b010, 32'h0000_0000, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        0, 2'b00, 1, 32'hDEAD_BEEF, 3);
        access("sb",   1, 3'b000, 32'h0000_0007, 32'h1122_3344, 0, 0, 1, 4'b1000, 32'h4444_4444, 0, 2'b00, 0, 32'h0,       2);
        access("lb",   0, 3'b000, 32'h0000_0007, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        0, 2'b00, 1, 32'h0000_0044, 3);
        access("tmo",  0, 3'b010, 32'h0000_0400, 32'h0,        0, 1, 1, 4'b0000, 32'h0,        1, 2'b10, 0, 32'h0,        5);

        // Reset pulsed while the load waits in RESP: everything clears, no Done.
        bus_q.push_back('{1'b0, 32'h100, 4'b0000, 32'h0});
        gnt_wait  = 0;
        no_rvalid = 1'b1;
        MemValid  = 1'b1;
        MemWrite  = 1'b0;
        funct3    = 3'b010;
        Addr      = 32'h100;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_done", {31'h0, Done}, 32'h0);
        check("mid_rst_fault", {31'h0, Fault}, 32'h0);
        check("mid_rst_cause", {30'h0, FaultCause}, 32'h0);
        check("mid_rst_lf3", {29'h0, LoadFunct3}, 32'h0);
        check("mid_rst_addr", DMemAddr, 32'h0);
        check("mid_rst_req", {31'h0, DMemReq}, 32'h0);
        MemValid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        no_rvalid = 1'b0;
        repeat (6) @(negedge clk);

        access("lbu2", 0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        0, 2'b00, 1, 32'h0000_00AA, 3);
        repeat (3) @(negedge clk);

        check("resp_q_empty", resp_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
